// File: rtl/coord2axis_pkg.sv
// Shared types for the coordinate-timed pixel to AXI4-Stream video bridge.
package coord2axis_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    STREAM,
    DROP
  } state_t;

  // Sideband tag stored alongside each pixel; FIFO entry layout is {tag, pixel}.
  typedef struct packed {
    logic tuser;
    logic tlast;
  } entry_tag_t;

  localparam int TAG_W = $bits(entry_tag_t);

endpackage

// File: rtl/coord2axis_fifo.sv
// Synchronous pixel FIFO with occupancy count; a write into a full FIFO
// is accepted only when a read happens in the same cycle.
module coord2axis_fifo
  import coord2axis_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coord2axis.sv
// Coordinate-timed pixel stream to AXI4-Stream video (VDMA S2MM), no input backpressure.
// Optional COORD2AXIS_DROP_CNT_EN adds a saturating count of frames that entered DROP.
module coord2axis
  import coord2axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = -1,
  parameter int V_ACTIVE   = -1,
  parameter int H_FRAME    = -1,
  parameter int V_FRAME    = -1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH*3-1:0]      in_data,
  input  logic [$clog2(V_FRAME)-1:0]   in_vcnt,
  input  logic [$clog2(H_FRAME)-1:0]   in_hcnt,
  input  logic                         in_vde,
  output logic [DATA_WIDTH*3-1:0]      m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         overflow
`ifdef COORD2AXIS_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int HW      = $clog2(H_FRAME);
  localparam int PIX_W   = DATA_WIDTH * 3;
  localparam int ENTRY_W = TAG_W + PIX_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [HW-1:0] EOL_H = HW'(H_ACTIVE - 1);

  state_t             state;
  state_t             state_next;
  logic               sof;
  logic               eol;
  logic               pop;
  logic               can_write;
  logic               wr_en;
  logic               ovf_set;
  entry_tag_t         wr_tag;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  assign sof       = in_vde && (in_vcnt == '0) && (in_hcnt == '0);
  assign eol       = in_vde && (in_hcnt == EOL_H);
  assign wr_tag    = '{tuser: sof, tlast: eol};
  assign m_axis_tvalid = (fifo_count != '0);
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign can_write = !fifo_full || pop;

  // Gate the FIFO head so the outputs read zero whenever nothing is queued.
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_empty ? '0 : rd_data;

  coord2axis_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({wr_tag, in_data}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    unique case (state)
      WAIT_SOF, DROP: begin
        if (sof) begin
          if (can_write) begin
            wr_en      = 1'b1;
            state_next = STREAM;
          end else begin
            ovf_set    = 1'b1;
            state_next = DROP;
          end
        end
      end
      STREAM: begin
        if (in_vde) begin
          if (can_write) begin
            wr_en = 1'b1;
          end else begin
            ovf_set    = 1'b1;
            state_next = DROP;
          end
        end
      end
      default: state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_SOF;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (ovf_set) overflow <= 1'b1;
    end
  end

`ifdef COORD2AXIS_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (state != DROP && state_next == DROP && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coord2axis.sv
// Self-checking bench for coord2axis: randomized pixels and tready against a
// queue-based reference of the frame-acceptance rules.
module tb_coord2axis;

  localparam int DW     = 8;
  localparam int HA     = 4;
  localparam int VA     = 2;
  localparam int HF     = 6;
  localparam int VF     = 4;
  localparam int DEPTH  = 4;
  localparam int PIX_W  = 3 * DW;
  localparam int EW     = PIX_W + 2;
  localparam int NFRAME = HF * VF;

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] in_data;
  logic [1:0]       in_vcnt;
  logic [2:0]       in_hcnt;
  logic             in_vde;
  logic [PIX_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tuser;
  logic             m_axis_tlast;
  logic             overflow;
`ifdef COORD2AXIS_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  coord2axis #(
    .DATA_WIDTH (DW),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .H_FRAME    (HF),
    .V_FRAME    (VF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_vcnt       (in_vcnt),
    .in_hcnt       (in_hcnt),
    .in_vde        (in_vde),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow)
`ifdef COORD2AXIS_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: pixels queued for output, pixels ever accepted, beats seen on the bus.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] acc_q[$];
  logic [EW-1:0] beats[$];
  bit            locked;
  bit            m_ovf;
  int            m_drops;
  bit            prev_stall;
  logic [EW-1:0] prev_out;

  task automatic drive(input bit vde, input int v, input int h, input bit rdy);
    logic [PIX_W-1:0] d;
    logic [EW-1:0]    ent;
    bit               pop;
    bit               room;
    bit               sof;
    bit               eol;
    @(negedge clk);
    if (m_axis_tvalid && rdy) beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    prev_stall    = m_axis_tvalid && !rdy;
    prev_out      = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    d             = PIX_W'($urandom);
    in_vde        = vde;
    in_vcnt       = 2'(v);
    in_hcnt       = 3'(h);
    in_data       = d;
    m_axis_tready = rdy;
    sof  = vde && (v == 0) && (h == 0);
    eol  = vde && (h == HA - 1);
    ent  = {sof, eol, d};
    pop  = (exp_q.size() != 0) && rdy;
    room = (exp_q.size() < DEPTH) || pop;
    if (pop) void'(exp_q.pop_front());
    if (locked) begin
      if (vde) begin
        if (room) begin
          exp_q.push_back(ent);
          acc_q.push_back(ent);
        end else begin
          locked = 1'b0;
          m_ovf  = 1'b1;
          m_drops++;
        end
      end
    end else if (sof) begin
      if (room) begin
        exp_q.push_back(ent);
        acc_q.push_back(ent);
        locked = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Drives n cycles (frame positions start.. when active, blanking otherwise)
  // and compares the bus against the reference after every clock edge.
  task automatic run_cycles(input int start, input int n, input bit active, input int mode);
    int  idx;
    int  v;
    int  h;
    bit  rdy;
    for (int i = 0; i < n; i++) begin
      idx = (start + i) % NFRAME;
      v   = active ? idx / HF : VF - 1;
      h   = active ? idx % HF : HF - 1;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(3) != 0);
      drive(active && v < VA && h < HA, v, h, rdy);
      @(posedge clk);
      #1;
      checks++;
      if (m_axis_tvalid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL tvalid t=%0t got %b want %b", $time, m_axis_tvalid, exp_q.size() != 0);
      end
      if (m_axis_tvalid && exp_q.size() != 0) begin
        checks++;
        if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
          failures++;
          $display("FAIL beat t=%0t got %h want %h", $time,
                   {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
        end
      end
      checks++;
      if (overflow !== m_ovf) begin
        failures++;
        $display("FAIL overflow t=%0t got %b want %b", $time, overflow, m_ovf);
      end
      if (prev_stall && m_axis_tvalid) begin
        checks++;
        if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_out) begin
          failures++;
          $display("FAIL stall_hold t=%0t got %h want %h", $time,
                   {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_out);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    in_vde        = 1'b0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    acc_q.delete();
    beats.delete();
    locked     = 1'b0;
    m_ovf      = 1'b0;
    m_drops    = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] out;
    out = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    checks++;
    if (m_axis_tvalid !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b out=%h want valid=0 out=0", m_axis_tvalid, out);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow got %b want 0", overflow);
    end
    checks++;
    if (dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got %0d want 0", dut.u_fifo.count);
    end
`ifdef COORD2AXIS_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_frame();
    logic [EW-1:0] b;
    do_reset();
    run_cycles(0, NFRAME, 1'b1, 0);
    run_cycles(0, 3, 1'b0, 0);
    checks++;
    if (beats.size() != 8) begin
      failures++;
      $display("FAIL frame_beats got %0d want 8", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      b = beats[i];
      checks++;
      if (b[EW-1] !== (i == 0) || b[EW-2] !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL frame_tags beat=%0d got user=%b last=%b want user=%b last=%b",
                 i, b[EW-1], b[EW-2], i == 0, i == 3 || i == 7);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL frame_overflow got %b want 0", overflow);
    end
  endtask

  task automatic test_pre_sof();
    logic [EW-1:0] b;
    do_reset();
    for (int h = 0; h < 3; h++) begin
      drive(1'b1, 1, h, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL pre_sof_valid h=%0d got %b want 0", h, m_axis_tvalid);
      end
    end
    run_cycles(0, NFRAME, 1'b1, 0);
    run_cycles(0, 2, 1'b0, 0);
    checks++;
    if (beats.size() != 8) begin
      failures++;
      $display("FAIL pre_sof_beats got %0d want 8", beats.size());
    end else begin
      b = beats[0];
      checks++;
      if (b[EW-1] !== 1'b1) begin
        failures++;
        $display("FAIL pre_sof_tuser got %b want 1", b[EW-1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [EW-1:0] b;
    do_reset();
    run_cycles(0, HF, 1'b1, 1);
    checks++;
    if (overflow !== 1'b0 || dut.u_fifo.count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_before got ovf=%b count=%0d want ovf=0 count=4", overflow, dut.u_fifo.count);
    end
    run_cycles(HF, 1, 1'b1, 1);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_5th_pixel got %b want 1", overflow);
    end
    run_cycles(HF + 1, NFRAME - HF - 1, 1'b1, 1);
    run_cycles(0, 6, 1'b0, 0);
    checks++;
    if (beats.size() != 4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drain got beats=%0d ovf=%b want beats=4 ovf=1", beats.size(), overflow);
    end
    run_cycles(0, NFRAME, 1'b1, 0);
    run_cycles(0, 2, 1'b0, 0);
    checks++;
    if (beats.size() != 12) begin
      failures++;
      $display("FAIL ovf_next_frame got beats=%0d want 12", beats.size());
    end else begin
      b = beats[4];
      checks++;
      if (b[EW-1] !== 1'b1) begin
        failures++;
        $display("FAIL ovf_next_tuser got %b want 1", b[EW-1]);
      end
    end
`ifdef COORD2AXIS_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      failures++;
      $display("FAIL drop_cnt got %0d want 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_full_pop();
    do_reset();
    run_cycles(0, HF, 1'b1, 1);
    checks++;
    if (dut.u_fifo.count !== 3'd4) begin
      failures++;
      $display("FAIL full_fill got count=%0d want 4", dut.u_fifo.count);
    end
    run_cycles(HF, 1, 1'b1, 0);
    checks++;
    if (dut.u_fifo.count !== 3'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop got count=%0d ovf=%b want count=4 ovf=0", dut.u_fifo.count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_cycles(0, HF, 1'b1, 0);
    run_cycles(HF, 2, 1'b1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b count=%0d want valid=0 count=0",
               m_axis_tvalid, dut.u_fifo.count);
    end
    do_reset();
    run_cycles(HF + 2, NFRAME - HF - 2, 1'b1, 0);
    checks++;
    if (beats.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet got beats=%0d want 0", beats.size());
    end
    run_cycles(0, NFRAME, 1'b1, 0);
    run_cycles(0, 2, 1'b0, 0);
    checks++;
    if (beats.size() != 8 || beats[0][EW-1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_resume got beats=%0d want 8 with tuser first", beats.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 3; f++) run_cycles(0, NFRAME, 1'b1, 2);
    run_cycles(0, 8, 1'b0, 0);
    checks++;
    if (beats.size() != acc_q.size()) begin
      failures++;
      $display("FAIL random_count got %0d want %0d", beats.size(), acc_q.size());
    end
    for (int i = 0; i < beats.size() && i < acc_q.size(); i++) begin
      checks++;
      if (beats[i] !== acc_q[i]) begin
        failures++;
        $display("FAIL random_seq beat=%0d got %h want %h", i, beats[i], acc_q[i]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    in_data       = '0;
    in_vcnt       = '0;
    in_hcnt       = '0;
    in_vde        = 1'b0;
    m_axis_tready = 1'b0;
    #12;
    test_reset();
    test_frame();
    test_pre_sof();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/coord2axis.md
COORD2AXIS -- requirements
Module: coord2axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per colour component (pixel = 3*DATA_WIDTH).
REQ-002 SHALL have parameters H_ACTIVE, V_ACTIVE, H_FRAME and V_FRAME, each default -1, giving active and total frame dimensions; each SHALL be overridden at instantiation.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, giving the pixel FIFO depth; it SHALL be a power of 2 and at least 4.
REQ-004 SHALL have port clk, input, width 1: the single clock.
REQ-005 SHALL have port rst, input, width 1: the reset, asynchronous and active-high.
REQ-006 SHALL have port in_data, input, width DATA_WIDTH*3: pixel, with R in the MSBs.
REQ-007 SHALL have port in_vcnt, input, width $clog2(V_FRAME): line coordinate.
REQ-008 SHALL have port in_hcnt, input, width $clog2(H_FRAME): column coordinate.
REQ-009 SHALL have port in_vde, input, width 1: pixel is active.
REQ-010 SHALL have port m_axis_tdata, output, width DATA_WIDTH*3: AXI4-Stream pixel.
REQ-011 SHALL have ports m_axis_tvalid (output), m_axis_tready (input), m_axis_tuser (output) and m_axis_tlast (output), each width 1; tuser marks SOF and tlast marks EOL.
REQ-012 SHALL have port overflow, output, width 1: sticky flag set when a pixel is lost.

Function
REQ-013 SHALL convert the coordinate-timed pixel stream into AXI4-Stream video for the VDMA S2MM port; there SHALL be no backpressure toward the input side.
REQ-014 SHALL implement a three-state FSM with these transitions:
- WAIT_SOF -> STREAM on an accepted SOF pixel.
- STREAM -> DROP on a write attempt while the FIFO is full.
- DROP -> STREAM on the next SOF pixel, if the FIFO is not full.
REQ-015 SHALL define a write attempt as in_vde=1 while in STREAM, or an SOF pixel while in WAIT_SOF or DROP.
REQ-016 SHALL define an SOF pixel as in_vde=1 with in_vcnt=0 and in_hcnt=0.
REQ-017 SHALL define an EOL pixel as in_vde=1 with in_hcnt=H_ACTIVE-1.
REQ-018 SHALL ignore all pixels in WAIT_SOF and in DROP except an SOF pixel.
REQ-019 SHALL store {tuser, tlast, data} per FIFO entry; tuser=1 only for the SOF pixel and tlast=1 only for EOL pixels.
REQ-020 SHALL make a pixel written in cycle N visible on m_axis at cycle N+1 at the earliest (latency 1).
REQ-021 SHALL assert m_axis_tvalid exactly when the FIFO is non-empty.
REQ-022 SHALL pop an entry only when m_axis_tvalid=1 and m_axis_tready=1.
REQ-023 SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while tvalid=1 and tready=0.
REQ-024 SHALL accept a write into a full FIFO if a pop occurs in the same cycle; otherwise the pixel SHALL be discarded, overflow SHALL set, and the FSM SHALL enter DROP.
REQ-025 SHALL keep draining entries already in the FIFO while in DROP, so the truncated frame is delivered without a final tlast.
REQ-026 SHALL discard an SOF pixel that arrives in DROP while the FIFO is full, with the FSM staying in DROP.
REQ-027 SHALL keep the FIFO occupancy count in $clog2(FIFO_DEPTH)+1 bits; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 SHALL treat an SOF pixel in STREAM as a normal write with tuser=1, with no state change.

Reset
REQ-029 SHALL, while rst=1, force:
- FSM to WAIT_SOF.
- FIFO empty, pointers 0.
- m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0.
- overflow=0.
REQ-030 SHALL discard FIFO contents on reset mid-frame; output SHALL resume only at the next SOF after rst deasserts.
REQ-031 SHALL clear overflow only by reset.

Configuration
REQ-032 SHALL, when COORD2AXIS_DROP_CNT_EN is defined, add output drop_cnt, width 16: a count of frames that entered DROP, saturating at 16'hFFFF, reset to 0.
REQ-033 SHALL, when COORD2AXIS_DROP_CNT_EN is undefined, omit the drop_cnt port and its logic; all other behaviour SHALL be identical.

Structure
REQ-034 SHALL place the FSM state enum (WAIT_SOF, STREAM, DROP) and the FIFO entry struct type in shared package coord2axis_pkg.
REQ-035 SHALL implement the FIFO as sub-module coord2axis_fifo (synchronous, with count, full and empty outputs); the FSM and SOF/EOL tagging SHALL live in coord2axis.

Verification
REQ-036 SHALL verify that with H_ACTIVE=4, V_ACTIVE=2 and tready=1, one frame yields 8 beats; tuser is set on beat 0 only, tlast on beats 3 and 7, and overflow=0.
REQ-037 SHALL verify that 3 active pixels arriving before the first SOF produce no beats, and that the first beat after SOF has tuser=1.
REQ-038 SHALL verify that with FIFO_DEPTH=4 and tready=0 for a full 4x2 frame:
- overflow=1 from the 5th pixel onward;
- 4 beats drain once tready=1;
- the next frame arrives complete with tuser=1;
- drop_cnt=1 when the macro is defined.
REQ-039 SHALL verify that a full FIFO with tready=1 and a simultaneous input pixel produces no overflow and leaves count unchanged at 4.
REQ-040 SHALL verify that asserting rst during line 1 of a frame sets tvalid=0 and count=0 within the same cycle, and that no beat appears until the next SOF.
REQ-041 SHALL verify that random tready over 3 frames produces beats that match the input pixel sequence exactly, with tdata stable across every stall.
